alu_cmd_sequencer: RTL

//  Upstream issue stage for the 4-bit combinational ALU. Buffers {a,b,op} commands
//  in a small FIFO and drives them into the ALU one at a time. Holds each command's

---
 rtl/alu_cmd_sequencer_if.sv | 25 ++
 rtl/alu_cmd_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between the ALU issue stage and its neighbours.
// The slave side is the sequencer; the master side is the command producer / result consumer.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic [2:0] res_op;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero, res_op
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero, res_op
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit combinational ALU: queues {a,b,op} commands, holds the ALU
// inputs for SETTLE cycles, captures result/carry and offers it on a valid/ready port.
module alu_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_cmd_sequencer_if.slave  bus,
    output logic [3:0]          alu_a_o,
    output logic [3:0]          alu_b_o,
    output logic [2:0]          alu_sel_o,
    input  logic [3:0]          alu_result_i,
    input  logic                alu_carry_i,
    output logic                busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_OUT} state_t;

    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    aluA_q, aluA_d, aluB_q, aluB_d;
    logic [2:0]    aluSel_q, aluSel_d;
    logic          resValid_q, resValid_d;
    logic [3:0]    resData_q, resData_d;
    logic          resCarry_q, resCarry_d;
    logic          resZero_q, resZero_d;
    logic [2:0]    resOp_q, resOp_d;
    logic          push, pop, empty, full;
    logic [10:0]   head;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.cmd_valid && !full;
    assign head  = mem_q[rdPtr_q];

    // Storage carries no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        aluA_d     = aluA_q;
        aluB_d     = aluB_q;
        aluSel_d   = aluSel_q;
        resValid_d = resValid_q;
        resData_d  = resData_q;
        resCarry_d = resCarry_q;
        resZero_d  = resZero_q;
        resOp_d    = resOp_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop                          = 1'b1;
                    {aluA_d, aluB_d, aluSel_d}   = head;
                    cnt_d                        = CW'(SETTLE);
                    state_d                      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    resValid_d = 1'b1;
                    resData_d  = alu_result_i;
                    resCarry_d = alu_carry_i;
                    resZero_d  = (alu_result_i == 4'h0);
                    resOp_d    = aluSel_q;
                    state_d    = ST_OUT;
                end
            end
            ST_OUT: begin
                // A waiting command is issued on the same edge the result is taken.
                if (bus.res_ready) begin
                    resValid_d = 1'b0;
                    if (!empty) begin
                        pop                        = 1'b1;
                        {aluA_d, aluB_d, aluSel_d} = head;
                        cnt_d                      = CW'(SETTLE);
                        state_d                    = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            aluA_q     <= '0;
            aluB_q     <= '0;
            aluSel_q   <= '0;
            resValid_q <= 1'b0;
            resData_q  <= '0;
            resCarry_q <= 1'b0;
            resZero_q  <= 1'b0;
            resOp_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            aluA_q     <= aluA_d;
            aluB_q     <= aluB_d;
            aluSel_q   <= aluSel_d;
            resValid_q <= resValid_d;
            resData_q  <= resData_d;
            resCarry_q <= resCarry_d;
            resZero_q  <= resZero_d;
            resOp_q    <= resOp_d;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.res_valid = resValid_q;
    assign bus.res_data  = resData_q;
    assign bus.res_carry = resCarry_q;
    assign bus.res_zero  = resZero_q;
    assign bus.res_op    = resOp_q;
    assign alu_a_o       = aluA_q;
    assign alu_b_o       = aluB_q;
    assign alu_sel_o     = aluSel_q;
    assign busy_o        = (state_q != ST_IDLE) || !empty;
endmodule
